// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t        : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   DMEM_*         : memory geometry (32 words of 32 bits, 5 index bits)
//   addr_in_range  : true when every address bit above the word index is zero
package dmem_pkg;

  localparam int DMEM_WORDS     = 32;
  localparam int DMEM_ADDR_BITS = 5;
  localparam int DMEM_WORD_W    = 32;

  typedef logic [DMEM_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic addr_in_range(input word_t addr, input int unsigned abits);
    return (addr >> abits) == '0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_32_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   p0_* / p1_*   : requester ports (req, write, addr, wdata in; ack, rdata, err out)
//   mem_*         : memory port (address, write data, MemWrite, MemRead out; read data in)
//   busy          : arbiter not idle
//   dbg_state     : arbiter FSM state, dbg_wait_cnt : starvation counter
//
// Handshake: a requester raises pN_req with write/addr/wdata stable and keeps
// them until pN_ack pulses for one cycle; rdata/err are valid only in that
// cycle. In the cycle after ack the requester drops req or presents a new
// request; a req seen while the arbiter is idle always starts a new access.
interface dmem_arbiter_32_if;
  import dmem_pkg::*;

  logic        p0_req;
  logic        p0_write;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_write;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic        busy;
  state_t      dbg_state;
  logic [3:0]  dbg_wait_cnt;

  modport slave (
    input  p0_req, p0_write, p0_addr, p0_wdata,
    input  p1_req, p1_write, p1_addr, p1_wdata,
    input  mem_read_data,
    output p0_ack, p0_rdata, p0_err,
    output p1_ack, p1_rdata, p1_err,
    output mem_address, mem_write_data, mem_write, mem_read,
    output busy, dbg_state, dbg_wait_cnt
  );

  modport master (
    output p0_req, p0_write, p0_addr, p0_wdata,
    output p1_req, p1_write, p1_addr, p1_wdata,
    output mem_read_data,
    input  p0_ack, p0_rdata, p0_err,
    input  p1_ack, p1_rdata, p1_err,
    input  mem_address, mem_write_data, mem_write, mem_read,
    input  busy, dbg_state, dbg_wait_cnt
  );

endinterface

// File: rtl/dmem_prio_sel.sv
// Combinational priority choice between the two requesters.
//   p0_req_i, p1_req_i : requests
//   wait_cnt_i         : consecutive port-0 grants while port 1 was pending
//   grant_valid_o      : some port is requesting
//   grant_sel_o        : 0 = port 0, 1 = port 1
module dmem_prio_sel #(
  parameter int MAX_WAIT = 4
) (
  input  logic       p0_req_i,
  input  logic       p1_req_i,
  input  logic [3:0] wait_cnt_i,
  output logic       grant_valid_o,
  output logic       grant_sel_o
);

  logic starved;

  // Port 1 overrides port 0 once it has watched MAX_WAIT port-0 grants go by.
  assign starved       = (wait_cnt_i == 4'(MAX_WAIT));
  assign grant_valid_o = p0_req_i | p1_req_i;
  assign grant_sel_o   = p1_req_i & (~p0_req_i | starved);

endmodule

// File: rtl/dmem_arbiter_32.sv
// Two-port arbiter in front of the 32-word data memory.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : requester ports p0 (high priority) / p1 (low priority with
//                  starvation guard), memory port, busy and debug state
// Each access runs IDLE -> ACCESS -> RESP: the winning request is latched in
// IDLE, the memory is strobed in ACCESS, and the ack pulses in RESP.
module dmem_arbiter_32
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = DMEM_ADDR_BITS,
  parameter int MAX_WAIT  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_arbiter_32_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        sel_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] p0_rdata_q;
  logic [31:0] p1_rdata_q;

  logic grant_valid;
  logic grant_sel;
  logic load;
  logic in_range;

  dmem_prio_sel #(.MAX_WAIT(MAX_WAIT)) u_prio_sel (
    .p0_req_i      (bus.p0_req),
    .p1_req_i      (bus.p1_req),
    .wait_cnt_i    (wait_cnt_q),
    .grant_valid_o (grant_valid),
    .grant_sel_o   (grant_sel)
  );

  assign load     = (state_q == ST_IDLE) && grant_valid;
  assign in_range = addr_in_range(addr_q, ADDR_BITS);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The counter only moves on IDLE arbitration decisions; it is cleared
  // whenever port 1 is served or stops asking, so it measures one wait.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_IDLE) begin
      if (!bus.p1_req || (grant_valid && grant_sel)) begin
        wait_cnt_d = 4'd0;
      end else if (grant_valid && !grant_sel && (wait_cnt_q != 4'(MAX_WAIT))) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  // Request latch: requester inputs are ignored once the access has started.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (load) begin
      sel_q   <= grant_sel;
      write_q <= grant_sel ? bus.p1_write : bus.p0_write;
      addr_q  <= grant_sel ? bus.p1_addr  : bus.p0_addr;
      wdata_q <= grant_sel ? bus.p1_wdata : bus.p0_wdata;
    end
  end

  // Read data capture at the edge ending ACCESS. Out-of-range accesses
  // (read or write) return zero; in-range writes leave rdata untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rdata_q <= 32'd0;
      p1_rdata_q <= 32'd0;
    end else if ((state_q == ST_ACCESS) && (!write_q || !in_range)) begin
      if (sel_q) p1_rdata_q <= in_range ? bus.mem_read_data : 32'd0;
      else       p0_rdata_q <= in_range ? bus.mem_read_data : 32'd0;
    end
  end

  // Outputs decoded from the state alone, so an asynchronous reset drops
  // the memory strobes in the same instant.
  always_comb begin
    bus.mem_address    = 32'd0;
    bus.mem_write_data = 32'd0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.p0_ack         = 1'b0;
    bus.p1_ack         = 1'b0;
    bus.p0_err         = 1'b0;
    bus.p1_err         = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        bus.mem_address    = addr_q;
        bus.mem_write_data = wdata_q;
        bus.mem_write      = write_q & in_range;
        bus.mem_read       = ~write_q & in_range;
      end
      ST_RESP: begin
        bus.p0_ack = ~sel_q;
        bus.p1_ack = sel_q;
        bus.p0_err = ~sel_q & ~in_range;
        bus.p1_err = sel_q & ~in_range;
      end
      default: ;
    endcase
  end

  assign bus.p0_rdata     = p0_rdata_q;
  assign bus.p1_rdata     = p1_rdata_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_wait_cnt = wait_cnt_q;

endmodule

// File: doc/dmem_arbiter_32.md
Name: dmem_arbiter_32

Overview:
Arbitrates two requesters onto the single port of the 32-word data memory.
- Port 0: processor load/store path, high priority.
- Port 1: loader/debug port, low priority, with a starvation guard.
- Sequences each access as IDLE -> ACCESS -> RESP, drives the memory's address, write-data, MemWrite and MemRead, registers the read data and returns a one-cycle ack.
- Sits between the pipeline MEM stage / debug loader and the data memory.

Parameters:
ADDR_BITS, 5, word-index bits used by the memory; addr[31:ADDR_BITS] must be zero.
MAX_WAIT, 4, consecutive port-0 grants allowed while port 1 is pending before port 1 is forced to win (1..15).

Ports:
clk  in  1  system clock, all state on posedge
reset_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held stable until p0_ack
p0_write  in  1  1 = write, 0 = read
p0_addr  in  32  word address
p0_wdata  in  32  write data
p0_ack  out  1  one-cycle completion pulse
p0_rdata  out  32  read data, valid while p0_ack=1
p0_err  out  1  address out of range, valid while p0_ack=1
p1_req, p1_write, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err: same as port 0, for port 1
mem_address  out  32  to memory address
mem_write_data  out  32  to memory WriteData
mem_write  out  1  to memory MemWrite
mem_read  out  1  to memory MemRead
mem_read_data  in  32  from memory ReadData (combinational)
busy  out  1  1 when state != IDLE

Behaviour:
Reset values:
- reset_n low asynchronously forces IDLE.
- All acks, errs, mem_write, mem_read and busy are 0.
- rdata registers, mem_address, mem_write_data and wait_cnt are 0.
- Reset asserted during ACCESS aborts the access and deasserts mem_write immediately; no partial write.

States:
- IDLE: arbitrate; any req -> ACCESS latching sel, write, addr, wdata. No req -> stay.
- ACCESS: mem_address/mem_write_data driven from the latch.
  - mem_write = write & in_range; mem_read = ~write & in_range.
  - Memory write commits at the posedge ending ACCESS.
  - For reads, mem_read_data is captured into p<sel>_rdata at that edge.
  - Always -> RESP.
- RESP: p<sel>_ack=1 for exactly this cycle; p<sel>_err = ~in_range. Always -> IDLE.
- All memory outputs are driven 0 outside ACCESS.

Latency and throughput:
- A req sampled in IDLE at cycle N gives ACCESS at N+1 and ack at N+2.
- Maximum rate is one access per 3 cycles.

Arbitration (IDLE only):
- Only p0 requesting -> p0. Only p1 requesting -> p1.
- Both requesting -> p0, unless wait_cnt == MAX_WAIT, in which case p1 wins.

wait_cnt (4-bit):
- Increments when p0 is granted while p1_req=1.
- Clears when p1 is granted or p1_req=0 in IDLE.
- Saturates at MAX_WAIT.

Range check:
- in_range = (addr[31:ADDR_BITS] == 0).
- Out of range: no memory strobe, rdata = 0, err = 1, normal ack timing.

Handshake rules:
- A requester must deassert req, or present a new request, in the cycle after its ack. A req still high in IDLE is a new access.
- A req dropped during ACCESS or RESP does not cancel: the write still commits and the ack still pulses.
- Request inputs are ignored outside IDLE because the latch holds them.
- The non-selected port's ack/err stay 0, and its rdata holds its previous value.

Decomposition:
- Shared package dmem_pkg: state encoding (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2), DMEM_WORDS=32, DMEM_ADDR_BITS=5, word width 32.
- One natural sub-module, dmem_prio_sel: combinational p0/p1 choice from reqs, wait_cnt and MAX_WAIT.
- FSM, latch and datapath stay in the top.

Test Plan:
1. Reset mid-access: reset_n low during ACCESS of a p0 write of 32'hFFFF0000 to addr 5 -> mem_write drops at once; word 5 unchanged; no ack; busy=0.
2. p0 write then read: write 32'hDEADBEEF to addr 3, then read addr 3 -> ack at N+2 each time; read shows p0_rdata=32'hDEADBEEF, p0_err=0.
3. Simultaneous requests: p0 reads addr 1, p1 writes 32'h12345678 to addr 2, both asserted in the same cycle -> p0 acked first, p1 acked 3 cycles later; word 2 = 32'h12345678.
4. Starvation: p0_req held continuously, p1_req held with MAX_WAIT=4 -> 4 p0 grants, then p1 granted; wait_cnt returns to 0.
5. Out of range: p1 write to addr 32'h00000040 -> no mem_write pulse; p1_ack=1, p1_err=1, p1_rdata=0; memory unchanged.
